// File: rtl/multi_clock_divider.sv
// N-channel integer clock divider with shadowed ratio updates, period ticks and status.
// Optional macro CLKDIV_SYNC_EN adds i_sync to restart every dividing channel together.
module multi_clock_divider #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned NUM_CH = 2
) (
   input  logic                    i_ref_clk,
   input  logic                    i_rst_n,
   input  logic [NUM_CH-1:0]       i_clk_en,
   input  logic [NUM_CH*WIDTH-1:0] i_div_ratio,
   input  logic [NUM_CH-1:0]       i_ratio_vld,
`ifdef CLKDIV_SYNC_EN
   input  logic                    i_sync,
`endif
   output logic [NUM_CH-1:0]       o_div_clk,
   output logic [NUM_CH-1:0]       o_tick,
   output logic [NUM_CH-1:0]       o_active
);

   logic sync;
`ifdef CLKDIV_SYNC_EN
   assign sync = i_sync;
`else
   assign sync = 1'b0;
`endif

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [WIDTH-1:0] cnt;
      logic [WIDTH-1:0] act_ratio;
      logic [WIDTH-1:0] shadow;
      logic             pending;
      logic             div_q;
      logic             tick_q;
      logic             en_q;

      logic             en;
      logic             vld;
      logic [WIDTH-1:0] ratio_in;
      logic [WIDTH-1:0] half;
      logic [WIDTH-1:0] cnt_inc;
      logic [WIDTH-1:0] entry_ratio;
      logic [WIDTH-1:0] bound_ratio;
      logic             bypass;
      logic             entry;
      logic             wrap;

      assign en       = i_clk_en[k];
      assign vld      = i_ratio_vld[k];
      assign ratio_in = i_div_ratio[k*WIDTH +: WIDTH];

      assign bypass  = !en || (act_ratio < WIDTH'(2));
      assign entry   = en && !en_q;
      // ceil(R/2) without a divider; wrap also catches an out-of-range count
      assign half    = (act_ratio >> 1) + WIDTH'(act_ratio[0]);
      assign wrap    = (cnt >= act_ratio - WIDTH'(1));
      assign cnt_inc = cnt + WIDTH'(1);

      // A strobe on a boundary edge wins over an older pending shadow
      assign entry_ratio = (pending && !vld) ? shadow : ratio_in;
      assign bound_ratio = vld ? ratio_in : shadow;

      always_ff @(posedge i_ref_clk) begin
         if (!i_rst_n) begin
            cnt       <= '0;
            act_ratio <= '0;
            shadow    <= '0;
            pending   <= 1'b0;
            div_q     <= 1'b0;
            tick_q    <= 1'b0;
            en_q      <= 1'b0;
         end else begin
            en_q <= en;
            if (vld) begin
               shadow  <= ratio_in;
               pending <= 1'b1;
            end

            if (!en) begin
               cnt    <= '0;
               div_q  <= 1'b0;
               tick_q <= 1'b0;
            end else if (entry) begin
               act_ratio <= entry_ratio;
               pending   <= 1'b0;
               cnt       <= '0;
               div_q     <= 1'b1;
               tick_q    <= 1'b1;
            end else if (bypass) begin
               cnt    <= '0;
               div_q  <= 1'b0;
               tick_q <= 1'b0;
               if (pending) begin
                  act_ratio <= shadow;
                  pending   <= vld;
                  div_q     <= (shadow >= WIDTH'(2));
                  tick_q    <= (shadow >= WIDTH'(2));
               end
            end else if (wrap || sync) begin
               cnt    <= '0;
               div_q  <= 1'b1;
               tick_q <= 1'b1;
               if (vld || pending) begin
                  act_ratio <= bound_ratio;
                  pending   <= 1'b0;
               end
            end else begin
               cnt    <= cnt_inc;
               div_q  <= (cnt_inc < half);
               tick_q <= 1'b0;
            end
         end
      end

      // Bypass passes the reference clock straight through
      assign o_div_clk[k] = bypass ? i_ref_clk : div_q;
      assign o_active[k]  = !bypass;
      assign o_tick[k]    = bypass ? (en && (act_ratio == WIDTH'(1))) : tick_q;
   end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider (2 channels, WIDTH=8); covers i_sync when CLKDIV_SYNC_EN is defined.
module tb_multi_clock_divider;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned NUM_CH = 2;

   logic                    clk;
   logic                    rst_n;
   logic [NUM_CH-1:0]       clk_en;
   logic [NUM_CH*WIDTH-1:0] div_ratio;
   logic [NUM_CH-1:0]       ratio_vld;
   logic                    sync;
   logic [NUM_CH-1:0]       div_clk;
   logic [NUM_CH-1:0]       tick;
   logic [NUM_CH-1:0]       active;

   int n_checks = 0;
   int n_pass   = 0;

   multi_clock_divider #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
`ifdef CLKDIV_SYNC_EN
      .i_sync      (sync),
`endif
      .i_ref_clk   (clk),
      .i_rst_n     (rst_n),
      .i_clk_en    (clk_en),
      .i_div_ratio (div_ratio),
      .i_ratio_vld (ratio_vld),
      .o_div_clk   (div_clk),
      .o_tick      (tick),
      .o_active    (active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ratio(input int ch, input logic [WIDTH-1:0] r);
      div_ratio[ch*WIDTH +: WIDTH] = r;
   endtask

   // Expected phase idx of a period with ratio r and high length h
   task automatic check_ch(input int ch, input int r, input int h, input int idx);
      check($sformatf("div ch%0d r%0d i%0d", ch, r, idx), 32'(div_clk[ch]), 32'(idx < h));
      check($sformatf("tick ch%0d r%0d i%0d", ch, r, idx), 32'(tick[ch]), 32'(idx == 0));
      check($sformatf("active ch%0d r%0d", ch, r), 32'(active[ch]), 32'd1);
   endtask

   task automatic check_cycles(input int ch, input int r, input int h, input int start, input int n);
      for (int i = start; i < start + n; i++) begin
         check_ch(ch, r, h, i % r);
         step();
      end
   endtask

   // ch0 ratio 3 (2 high), ch1 ratio 4 (2 high)
   task automatic check_dual(input int i0, input int i1, input int n);
      for (int i = 0; i < n; i++) begin
         check_ch(0, 3, 2, (i0 + i) % 3);
         check_ch(1, 4, 2, (i1 + i) % 4);
         step();
      end
   endtask

   task automatic enter(input int ch, input logic [WIDTH-1:0] r);
      clk_en[ch] = 1'b0;
      step();
      set_ratio(ch, r);
      clk_en[ch] = 1'b1;
      step();
   endtask

   initial begin
      rst_n     = 1'b0;
      clk_en    = '0;
      div_ratio = '0;
      ratio_vld = '0;
      sync      = 1'b0;
      step();
      step();
      check("rst active", 32'(active), 32'd0);
      check("rst tick", 32'(tick), 32'd0);
      check("rst div_clk high", 32'(div_clk), 32'd3);
      #5;
      check("rst div_clk low", 32'(div_clk), 32'd0);
      rst_n = 1'b1;
      step();

      // Basic ratios
      enter(0, 8'd4);
      check_cycles(0, 4, 2, 0, 8);
      enter(0, 8'd5);
      check_cycles(0, 5, 3, 0, 10);
      enter(0, 8'd2);
      check_cycles(0, 2, 1, 0, 4);
      enter(0, 8'd255);
      check_cycles(0, 255, 128, 0, 256);

      // Bypass: ratio 0 and ratio 1
      enter(0, 8'd0);
      check("r0 active", 32'(active[0]), 32'd0);
      check("r0 tick", 32'(tick[0]), 32'd0);
      check("r0 div_clk high", 32'(div_clk[0]), 32'd1);
      #5;
      check("r0 div_clk low", 32'(div_clk[0]), 32'd0);
      enter(0, 8'd1);
      for (int i = 0; i < 3; i++) begin
         check("r1 tick", 32'(tick[0]), 32'd1);
         check("r1 active", 32'(active[0]), 32'd0);
         step();
      end

      // Ratio 6 with strobe of 3 at cnt=2: full 6-cycle period first
      enter(0, 8'd6);
      check_cycles(0, 6, 3, 0, 2);
      set_ratio(0, 8'd3);
      ratio_vld[0] = 1'b1;
      check_cycles(0, 6, 3, 2, 1);
      ratio_vld[0] = 1'b0;
      check_cycles(0, 6, 3, 3, 3);
      check_cycles(0, 3, 2, 0, 3);

      // Two strobes before the wrap: last one (8) wins
      set_ratio(0, 8'd5);
      ratio_vld[0] = 1'b1;
      check_cycles(0, 3, 2, 0, 1);
      set_ratio(0, 8'd8);
      check_cycles(0, 3, 2, 1, 1);
      ratio_vld[0] = 1'b0;
      check_cycles(0, 3, 2, 2, 1);
      check_cycles(0, 8, 4, 0, 7);

      // Strobe on the wrap edge itself is applied at that wrap
      set_ratio(0, 8'd2);
      ratio_vld[0] = 1'b1;
      check_cycles(0, 8, 4, 7, 1);
      ratio_vld[0] = 1'b0;
      check_cycles(0, 2, 1, 0, 6);

      // Dual channel, ch1 enable toggled mid-period
      clk_en = 2'b00;
      step();
      set_ratio(0, 8'd3);
      set_ratio(1, 8'd4);
      clk_en = 2'b11;
      step();
      check_dual(0, 0, 6);
      clk_en[1] = 1'b0;
      #1;
      check("dis ch1 active same cycle", 32'(active[1]), 32'd0);
      check_ch(0, 3, 2, 0);
      step();
      check_ch(0, 3, 2, 1);
      check("dis ch1 active", 32'(active[1]), 32'd0);
      check("dis ch1 tick", 32'(tick[1]), 32'd0);
      check("dis ch1 div_clk", 32'(div_clk[1]), 32'd1);
      clk_en[1] = 1'b1;
      step();
      check_dual(2, 0, 8);

      // Reset mid-period, with a simultaneous strobe that must be dropped
      rst_n     = 1'b0;
      set_ratio(0, 8'd6);
      set_ratio(1, 8'd6);
      ratio_vld = 2'b11;
      step();
      check("mid rst active", 32'(active), 32'd0);
      check("mid rst tick", 32'(tick), 32'd0);
      check("mid rst div_clk high", 32'(div_clk), 32'd3);
      #5;
      check("mid rst div_clk low", 32'(div_clk), 32'd0);
      rst_n     = 1'b1;
      ratio_vld = 2'b00;
      set_ratio(0, 8'd3);
      set_ratio(1, 8'd4);
      step();
      check_dual(0, 0, 8);

`ifdef CLKDIV_SYNC_EN
      // Misaligned ratios 2 and 4, then a sync pulse aligns the ticks
      clk_en = 2'b00;
      step();
      set_ratio(0, 8'd2);
      set_ratio(1, 8'd4);
      clk_en = 2'b10;
      step();
      step();
      clk_en = 2'b11;
      step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check_ch(0, 2, 1, i % 2);
         check_ch(1, 4, 2, i % 4);
         step();
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
